// File: rtl/div_unit_pkg.sv
// Shared ALU operation codes and divider state encoding.
// Also holds small op-classification helpers used by div_unit.
package div_unit_pkg;

    localparam logic [4:0] ALU_DIV  = 5'b01110;
    localparam logic [4:0] ALU_DIVU = 5'b01111;
    localparam logic [4:0] ALU_REM  = 5'b10000;
    localparam logic [4:0] ALU_REMU = 5'b10001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        case (op)
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: is_div_op = 1'b1;
            default:                              is_div_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        is_signed_op = (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        is_rem_op = (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_acc,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_acc_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] diff_s;

    assign shifted_s = {rem_acc, quot[WIDTH-1]};
    assign diff_s    = shifted_s - {1'b0, divisor};

    // Keep the difference only when the trial subtraction did not borrow.
    always_comb begin
        rem_acc_next = shifted_s[WIDTH-1:0];
        quot_next    = {quot[WIDTH-2:0], 1'b0};
        if (!diff_s[WIDTH]) begin
            rem_acc_next = diff_s[WIDTH-1:0];
            quot_next    = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_acc_next = shifted_s[WIDTH-1:0];
            quot_next    = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider for div/divu/rem/remu; stalls the pipeline via busy_o
// and reports a registered result with a one-cycle done_o pulse.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [4:0]       alu_op_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_r;
    logic             rem_op_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_acc_r;
    logic [WIDTH-1:0] quot_r;
    logic [CNT_W-1:0] count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;

    logic             accept_s;
    logic             signed_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic             special_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic [WIDTH-1:0] special_res_s;
    logic [WIDTH-1:0] quot_fin_s;
    logic [WIDTH-1:0] rem_fin_s;
    logic [WIDTH-1:0] rem_acc_step_s;
    logic [WIDTH-1:0] quot_step_s;

    assign accept_s = start_i && is_div_op(alu_op_i);
    assign signed_s = is_signed_op(alu_op_i);
    assign a_neg_s  = signed_s && op_a_i[WIDTH-1];
    assign b_neg_s  = signed_s && op_b_i[WIDTH-1];

    // Operand magnitudes, early-out detection and the final sign fix-up.
    always_comb begin
        abs_a_s       = op_a_i;
        abs_b_s       = op_b_i;
        special_s     = 1'b0;
        special_res_s = ZERO;
        if (a_neg_s) begin
            abs_a_s = -op_a_i;
        end else begin
            abs_a_s = op_a_i;
        end
        if (b_neg_s) begin
            abs_b_s = -op_b_i;
        end else begin
            abs_b_s = op_b_i;
        end
        // Divide-by-zero takes precedence; overflow only exists for signed ops.
        if (op_b_i == ZERO) begin
            special_s     = 1'b1;
            special_res_s = is_rem_op(alu_op_i) ? op_a_i : ALL_ONES;
        end else if (signed_s && (op_a_i == MIN_NEG) && (op_b_i == ALL_ONES)) begin
            special_s     = 1'b1;
            special_res_s = is_rem_op(alu_op_i) ? ZERO : MIN_NEG;
        end else begin
            special_s     = 1'b0;
            special_res_s = ZERO;
        end
        quot_fin_s = (sign_a_r ^ sign_b_r) ? -quot_r : quot_r;
        rem_fin_s  = sign_a_r ? -rem_acc_r : rem_acc_r;
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_acc      (rem_acc_r),
        .quot         (quot_r),
        .divisor      (divisor_r),
        .rem_acc_next (rem_acc_step_s),
        .quot_next    (quot_step_s)
    );

    // Divider FSM with registered busy/done/result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            rem_op_r  <= 1'b0;
            sign_a_r  <= 1'b0;
            sign_b_r  <= 1'b0;
            divisor_r <= ZERO;
            rem_acc_r <= ZERO;
            quot_r    <= ZERO;
            count_r   <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= ZERO;
        end else if (flush_i) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s) begin
                        rem_op_r  <= is_rem_op(alu_op_i);
                        sign_a_r  <= a_neg_s;
                        sign_b_r  <= b_neg_s;
                        divisor_r <= abs_b_s;
                        quot_r    <= abs_a_s;
                        rem_acc_r <= ZERO;
                        count_r   <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        if (special_s) begin
                            result_r <= special_res_s;
                            done_r   <= 1'b1;
                            state_r  <= ST_DONE;
                        end else begin
                            state_r  <= ST_CALC;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    rem_acc_r <= rem_acc_step_s;
                    quot_r    <= quot_step_s;
                    count_r   <= count_r + CNT_ONE;
                    if (count_r == CNT_LAST) begin
                        state_r <= ST_SIGN;
                    end else begin
                        state_r <= ST_CALC;
                    end
                end
                ST_SIGN: begin
                    result_r <= rem_op_r ? rem_fin_s : quot_fin_s;
                    done_r   <= 1'b1;
                    state_r  <= ST_DONE;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;

endmodule
